// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART command-frame sequencer.
package uart_pkg;

    localparam int unsigned DEF_MAX_LEN     = 16;
    localparam int unsigned DEF_TIMEOUT_CYC = 50000;
    localparam logic [7:0]  DEF_SOF_BYTE    = 8'hAA;
    localparam int unsigned LW              = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_HOLD
    } state_e;

    typedef struct packed {
        logic [7:0]    cmd;
        logic [LW-1:0] len;
    } frm_hdr_t;

endpackage

// File: rtl/uart_frame_ctrl_if.sv
// Receiver-side byte strobe plus host-side frame hand-off signals.
interface uart_frame_ctrl_if;
    import uart_pkg::*;

    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic          frm_valid;
    logic [7:0]    frm_cmd;
    logic [LW-1:0] frm_len;
    logic [LW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          frm_ack;
    logic          err_chk;
    logic          err_len;
    logic          err_tmo;
    logic          err_ovr;
    logic          busy;

    modport slave (
        input  rx_valid, rx_byte, rd_addr, frm_ack,
        output frm_valid, frm_cmd, frm_len, rd_data,
        output err_chk, err_len, err_tmo, err_ovr, busy
    );

    modport master (
        output rx_valid, rx_byte, rd_addr, frm_ack,
        input  frm_valid, frm_cmd, frm_len, rd_data,
        input  err_chk, err_len, err_tmo, err_ovr, busy
    );

endinterface

// File: rtl/uart_frame_tmo.sv
// Inter-byte idle counter: cleared on each accepted byte, runs while enabled.
module uart_frame_tmo #(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] cnt;

    // Expires in the idle cycle whose count reaches TIMEOUT_CYC-1; a byte in that cycle wins.
    assign expire_c = en & ~clr & (cnt == CW'(TIMEOUT_CYC - 2));

    // Idle cycle counter, held at zero outside the frame body.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (!expire_c) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Parses SOF/CMD/LEN/payload/CHK frames from the UART byte stream and holds good frames for the host.
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned MAX_LEN     = DEF_MAX_LEN,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter logic [7:0]  SOF_BYTE    = DEF_SOF_BYTE
) (
    input  logic             clk,
    input  logic             rst,
    uart_frame_ctrl_if.slave bus
);

    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_e        state_q, state_d;
    frm_hdr_t      cur_q, cur_d;
    frm_hdr_t      hdr_q;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [7:0]    sum_q, sum_d;
    logic          rx_valid_q;
    logic          acc_c;
    logic          wr_en_c;
    logic          hdr_load_c;
    logic          tmo_en_c;
    logic          tmo_exp_c;
    logic          err_chk_d, err_len_d, err_tmo_d, err_ovr_d;
    logic [7:0]    pay_mem [MAX_LEN];

    assign acc_c    = bus.rx_valid & ~rx_valid_q;
    assign tmo_en_c = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                      (state_q == ST_DATA) || (state_q == ST_CHK);

    uart_frame_tmo #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .clr      (acc_c),
        .en       (tmo_en_c),
        .expire_c (tmo_exp_c)
    );

    // Next-state, frame field capture and error pulse decode.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        wr_en_c    = 1'b0;
        hdr_load_c = 1'b0;
        err_chk_d  = 1'b0;
        err_len_d  = 1'b0;
        err_tmo_d  = 1'b0;
        err_ovr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (acc_c && bus.rx_byte == SOF_BYTE) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (acc_c) begin
                    cur_d.cmd = bus.rx_byte;
                    sum_d     = bus.rx_byte;
                    state_d   = ST_LEN;
                end
            end
            ST_LEN: begin
                if (acc_c) begin
                    if (bus.rx_byte > 8'(MAX_LEN)) begin
                        err_len_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        cur_d.len = LW'(bus.rx_byte);
                        sum_d     = sum_q + bus.rx_byte;
                        cnt_d     = '0;
                        state_d   = (bus.rx_byte == 8'h00) ? ST_CHK : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (acc_c) begin
                    wr_en_c = 1'b1;
                    sum_d   = sum_q + bus.rx_byte;
                    cnt_d   = cnt_q + LW'(1);
                    if (cnt_q == cur_q.len - LW'(1)) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (acc_c) begin
                    if (bus.rx_byte == sum_q) begin
                        hdr_load_c = 1'b1;
                        state_d    = ST_HOLD;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                // A byte here is dropped even if it coincides with the ack, so no SOF is taken.
                if (acc_c) begin
                    err_ovr_d = 1'b1;
                end
                if (bus.frm_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (tmo_exp_c) begin
            err_tmo_d = 1'b1;
            state_d   = ST_IDLE;
        end
    end

    // State, working fields and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rx_valid_q    <= 1'b0;
            cur_q         <= '0;
            hdr_q         <= '0;
            cnt_q         <= '0;
            sum_q         <= '0;
            bus.frm_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.err_chk   <= 1'b0;
            bus.err_len   <= 1'b0;
            bus.err_tmo   <= 1'b0;
            bus.err_ovr   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_valid_q    <= bus.rx_valid;
            cur_q         <= cur_d;
            cnt_q         <= cnt_d;
            sum_q         <= sum_d;
            if (hdr_load_c) begin
                hdr_q <= cur_q;
            end
            bus.frm_valid <= (state_d == ST_HOLD);
            bus.busy      <= (state_d != ST_IDLE);
            bus.err_chk   <= err_chk_d;
            bus.err_len   <= err_len_d;
            bus.err_tmo   <= err_tmo_d;
            bus.err_ovr   <= err_ovr_d;
        end
    end

    // Payload buffer; contents after reset are irrelevant.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_c) begin
            pay_mem[AW'(cnt_q)] <= bus.rx_byte;
        end
    end

    assign bus.frm_cmd = hdr_q.cmd;
    assign bus.frm_len = hdr_q.len;
    assign bus.rd_data = (bus.rd_addr < hdr_q.len) ? pay_mem[AW'(bus.rd_addr)] : 8'h00;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Frame-level checks of uart_frame_ctrl: directed cases plus randomized frames.
module tb_uart_frame_ctrl;
    import uart_pkg::*;

    localparam int unsigned TMO  = 100;
    localparam int unsigned MLEN = DEF_MAX_LEN;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_frame_ctrl_if bus ();

    uart_frame_ctrl #(
        .MAX_LEN    (MLEN),
        .TIMEOUT_CYC(TMO),
        .SOF_BYTE   (8'hAA)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int n_chk = 0, n_len = 0, n_tmo = 0, n_ovr = 0, n_multi = 0;
    int e_chk = 0, e_len = 0, e_tmo = 0, e_ovr = 0;
    logic [7:0] last_cmd = 8'h00;
    int         last_len = 0;
    logic [7:0] pay[$];
    logic [7:0] fb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count error pulses between edges.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            n_chk += int'(bus.err_chk);
            n_len += int'(bus.err_len);
            n_tmo += int'(bus.err_tmo);
            n_ovr += int'(bus.err_ovr);
            if (int'(bus.err_chk) + int'(bus.err_len) + int'(bus.err_tmo) + int'(bus.err_ovr) > 1)
                n_multi++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int hi, input int gap);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        repeat (hi) @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic rand_pay(input int n);
        pay = {};
        repeat (n) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    // Frame bytes: SOF, CMD, LEN, payload, checksum (xored with bad to corrupt it).
    task automatic build(input logic [7:0] cmd, input logic [7:0] len, input logic [7:0] bad);
        int s;
        s  = int'(cmd) + int'(len);
        fb = {};
        fb.push_back(8'hAA);
        fb.push_back(cmd);
        fb.push_back(len);
        foreach (pay[i]) begin
            fb.push_back(pay[i]);
            s += int'(pay[i]);
        end
        fb.push_back(8'(s % 256) ^ bad);
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++)
            send_byte(fb[i], $urandom_range(1, 3), $urandom_range(1, 4));
    endtask

    task automatic check_held(input string tag, input logic [7:0] cmd, input int len);
        int a;
        check({tag, "_valid"}, 32'(bus.frm_valid), 1);
        check({tag, "_busy"},  32'(bus.busy), 1);
        check({tag, "_cmd"},   32'(bus.frm_cmd), 32'(cmd));
        check({tag, "_len"},   32'(bus.frm_len), 32'(len));
        for (int i = 0; i < len; i++) begin
            bus.rd_addr = LW'(i);
            #1;
            check({tag, "_rd"}, 32'(bus.rd_data), 32'(pay[i]));
        end
        a = $urandom_range(len, (1 << LW) - 1);
        bus.rd_addr = LW'(a);
        #1;
        check({tag, "_rd_oob"}, 32'(bus.rd_data), 0);
        last_cmd = cmd;
        last_len = len;
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid0"},  32'(bus.frm_valid), 0);
        check({tag, "_busy0"},   32'(bus.busy), 0);
        check({tag, "_cmd_keep"}, 32'(bus.frm_cmd), 32'(last_cmd));
        check({tag, "_len_keep"}, 32'(bus.frm_len), 32'(last_len));
        check({tag, "_n_chk"},   n_chk, e_chk);
        check({tag, "_n_len"},   n_len, e_len);
        check({tag, "_n_tmo"},   n_tmo, e_tmo);
        check({tag, "_n_ovr"},   n_ovr, e_ovr);
        check({tag, "_multi"},   n_multi, 0);
    endtask

    task automatic ack();
        bus.frm_ack = 1'b1;
        @(negedge clk);
        bus.frm_ack = 1'b0;
    endtask

    initial begin
        int k, len, n;
        logic [7:0] c, g;

        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        bus.rd_addr  = '0;
        bus.frm_ack  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.frm_valid), 0);
        check("rst_busy",  32'(bus.busy), 0);
        check("rst_cmd",   32'(bus.frm_cmd), 0);
        check("rst_len",   32'(bus.frm_len), 0);
        check("rst_err",   32'({bus.err_chk, bus.err_len, bus.err_tmo, bus.err_ovr}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic good frame.
        pay = {8'h10, 8'h20, 8'h30};
        build(8'h01, 8'd3, 8'h00);
        send_n(fb.size());
        check_held("t1", 8'h01, 3);
        ack();
        check_idle("t1");

        // Checksum error (good CHK 3A replaced by 00), then a good frame.
        pay = {8'h11, 8'h22};
        build(8'h05, 8'd2, 8'h3A);
        send_n(fb.size());
        e_chk++;
        check_idle("t2");
        rand_pay(4);
        build(8'h09, 8'd4, 8'h00);
        send_n(fb.size());
        check_held("t2b", 8'h09, 4);
        ack();
        check_idle("t2b");

        // Length error, then 55 discarded and an empty-payload frame.
        fb = {8'hAA, 8'h02, 8'h11};
        send_n(3);
        e_len++;
        check_idle("t3");
        send_byte(8'h55, 1, 2);
        pay = {};
        build(8'h07, 8'd0, 8'h00);
        send_n(fb.size());
        check_held("t3b", 8'h07, 0);
        ack();
        check_idle("t3b");

        // Timeout fires TMO-1 cycles after the last byte.
        send_byte(8'hAA, 1, 2);
        send_byte(8'h01, 1, 0);
        repeat (TMO - 2) @(negedge clk);
        check("t4_pre_tmo", 32'(bus.err_tmo), 0);
        check("t4_pre_busy", 32'(bus.busy), 1);
        @(negedge clk);
        check("t4_tmo", 32'(bus.err_tmo), 1);
        e_tmo++;
        @(negedge clk);
        check_idle("t4");
        // A byte in the expiry cycle suppresses the timeout.
        send_byte(8'hAA, 1, 2);
        send_byte(8'h01, 1, 0);
        repeat (TMO - 2) @(negedge clk);
        send_byte(8'h00, 1, 2);
        send_byte(8'h01, 1, 2);
        pay = {};
        check_held("t4b", 8'h01, 0);
        ack();
        check_idle("t4b");

        // Overruns while held, including one in the ack cycle.
        rand_pay(2);
        build(8'h5A, 8'd2, 8'h00);
        send_n(fb.size());
        check_held("t5", 8'h5A, 2);
        send_byte(8'h33, 1, 2);
        e_ovr++;
        check("t5_ovr1", n_ovr, e_ovr);
        check("t5_still_valid", 32'(bus.frm_valid), 1);
        bus.rx_byte  = 8'h44;
        bus.rx_valid = 1'b1;
        bus.frm_ack  = 1'b1;
        @(negedge clk);
        bus.frm_ack  = 1'b0;
        bus.rx_valid = 1'b0;
        e_ovr++;
        @(negedge clk);
        check_idle("t5");

        // Reset during DATA aborts silently.
        rand_pay(5);
        build(8'h66, 8'd5, 8'h00);
        send_n(5);
        check("t6_busy_pre", 32'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_out", 32'({bus.frm_valid, bus.busy, bus.frm_cmd, bus.frm_len,
                                 bus.err_chk, bus.err_len, bus.err_tmo, bus.err_ovr}), 0);
        rst = 1'b0;
        last_cmd = 8'h00;
        last_len = 0;
        @(negedge clk);
        check_idle("t6");
        // Level held high counts once per byte.
        rand_pay(1);
        build(8'h21, 8'd1, 8'h00);
        foreach (fb[i]) send_byte(fb[i], 10, 2);
        check_held("t6b", 8'h21, 1);
        ack();
        check_idle("t6b");

        // Randomized frames.
        for (int it = 0; it < 30; it++) begin
            k = $urandom_range(0, 3);
            c = 8'($urandom_range(0, 255));
            case (k)
                0: begin
                    repeat ($urandom_range(0, 2)) begin
                        g = 8'($urandom_range(0, 255));
                        if (g == 8'hAA) g = 8'h55;
                        send_byte(g, 1, $urandom_range(1, 3));
                    end
                    len = $urandom_range(0, MLEN);
                    rand_pay(len);
                    build(c, 8'(len), 8'h00);
                    send_n(fb.size());
                    check_held("rg", c, len);
                    repeat ($urandom_range(0, 2)) begin
                        send_byte(8'($urandom_range(0, 255)), 1, 2);
                        e_ovr++;
                    end
                    if ($urandom_range(0, 1) == 1) begin
                        bus.rx_byte  = 8'hAA;
                        bus.rx_valid = 1'b1;
                        bus.frm_ack  = 1'b1;
                        @(negedge clk);
                        bus.frm_ack  = 1'b0;
                        bus.rx_valid = 1'b0;
                        e_ovr++;
                        @(negedge clk);
                    end else begin
                        ack();
                    end
                    check_idle("rg");
                end
                1: begin
                    len = $urandom_range(0, MLEN);
                    rand_pay(len);
                    build(c, 8'(len), 8'($urandom_range(1, 255)));
                    send_n(fb.size());
                    e_chk++;
                    check_idle("rc");
                end
                2: begin
                    fb = {8'hAA, c, 8'($urandom_range(MLEN + 1, 255))};
                    send_n(3);
                    e_len++;
                    check_idle("rl");
                end
                default: begin
                    len = $urandom_range(0, MLEN);
                    rand_pay(len);
                    build(c, 8'(len), 8'h00);
                    n = $urandom_range(1, fb.size() - 1);
                    send_n(n);
                    repeat (TMO + 2) @(negedge clk);
                    e_tmo++;
                    check_idle("rt");
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
